// File: rtl/fifo_pkt_writer.sv
// Packet framer for the async FIFO write port.
// Emits header (seq), payload, trailer (XOR checksum).
module fifo_pkt_writer #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             wr_clk,
  input  logic             wr_rstn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  output logic [15:0]      pkt_count,
  output logic             trunc_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, DATA, TRL, TRL_T, DROP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic [WIDTH-1:0] csum_q, csum_d;
  logic [CW-1:0]    len_q, len_d;
  logic [15:0]      pkt_q, pkt_d;
  logic             trunc_q, trunc_d;

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q <= IDLE;
      seq_q   <= '0;
      csum_q  <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    len_d   = len_q;
    pkt_d   = pkt_q;
    trunc_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid && !fifo_full) begin
          csum_d  = '0;
          len_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (s_valid && !fifo_full) begin
          csum_d = csum_q ^ s_data;
          len_d  = len_q + CW'(1);
          if (s_last)
            state_d = TRL;
          else if (len_q + CW'(1) == CW'(MAX_LEN))
            state_d = TRL_T;
        end
      end
      TRL, TRL_T: begin
        if (!fifo_full) begin
          seq_d   = seq_q + WIDTH'(1);
          pkt_d   = pkt_q + 16'd1;
          trunc_d = (state_q == TRL_T);
          state_d = (state_q == TRL_T) ? DROP : IDLE;
        end
      end
      DROP: begin
        if (s_valid && s_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready      = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        fifo_wr_en = s_valid && !fifo_full;
        if (fifo_wr_en)
          fifo_wr_data = seq_q;
      end
      DATA: begin
        s_ready      = !fifo_full;
        fifo_wr_en   = s_valid && !fifo_full;
        fifo_wr_data = s_data;
      end
      TRL, TRL_T: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = csum_q;
      end
      DROP: s_ready = 1'b1;
      default: ;
    endcase
  end

  assign pkt_count = pkt_q;
  assign trunc_err = trunc_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed bench for fifo_pkt_writer (MAX_LEN=4).
// FIFO writes are logged at negedge and compared to hand-built lists.
module tb_fifo_pkt_writer;

  localparam int W  = 8;
  localparam int ML = 4;

  logic         wr_clk = 1'b0;
  logic         wr_rstn;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [W-1:0] fifo_wr_data;
  logic [15:0]  pkt_count;
  logic         trunc_err;
  logic         busy;

  fifo_pkt_writer #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .wr_clk      (wr_clk),
    .wr_rstn     (wr_rstn),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .pkt_count   (pkt_count),
    .trunc_err   (trunc_err),
    .busy        (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tpulse = 0;
  int fullc  = 0;
  int fullbad = 0;
  logic [W-1:0] wq[$];
  int           cq[$];

  always @(posedge wr_clk) cyc <= cyc + 1;

  always @(negedge wr_clk) begin
    if (fifo_wr_en) begin
      wq.push_back(fifo_wr_data);
      cq.push_back(cyc);
    end
    if (trunc_err) tpulse++;
    if (fifo_full) begin
      fullc++;
      if (s_ready || fifo_wr_en) fullbad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int base,
                              input logic [W-1:0] e[$], input bit contig);
    check({tag, " count"}, wq.size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < wq.size(); i++) begin
      check($sformatf("%s w%0d", tag, i), wq[base+i], e[i]);
      if (contig)
        check($sformatf("%s c%0d", tag, i), cq[base+i] - cq[base], i);
    end
  endtask

  task automatic do_reset();
    wr_rstn   = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    fifo_full = 1'b0;
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    @(posedge wr_clk); #1;
  endtask

  task automatic idle_in();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_pkt(input logic [W-1:0] w[$], input bit mark_last);
    bit acc;
    for (int i = 0; i < w.size(); i++) begin
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = mark_last && (i == w.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge wr_clk);
        acc = s_ready;
        @(posedge wr_clk); #1;
      end
      if (!acc) check("accept timeout", 0, 1);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge wr_clk);
      done = !busy;
    end
    check("idle timeout", done, 1);
    @(posedge wr_clk); #1;
  endtask

  initial begin
    logic [W-1:0] p[$];
    logic [W-1:0] e[$];
    int base, tb0, fb0, fbad0;

    wr_rstn   = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    fifo_full = 1'b0;
    #12;
    check("rst s_ready", s_ready, 0);
    check("rst wr_en", fifo_wr_en, 0);
    check("rst wr_data", fifo_wr_data, 0);
    check("rst pkt_count", pkt_count, 0);
    check("rst trunc", trunc_err, 0);
    check("rst busy", busy, 0);
    do_reset();

    // basic three-word packet
    base = wq.size();
    p = '{8'h11, 8'h22, 8'h44};
    send_pkt(p, 1); idle_in(); wait_idle();
    e = '{8'h00, 8'h11, 8'h22, 8'h44, 8'h77};
    check_writes("basic", base, e, 1);
    check("basic pkt_count", pkt_count, 1);
    check("basic busy", busy, 0);

    // back-to-back, single-word first
    do_reset();
    base = wq.size();
    p = '{8'hA5}; send_pkt(p, 1);
    p = '{8'h01, 8'h02}; send_pkt(p, 1);
    idle_in(); wait_idle();
    e = '{8'h00, 8'hA5, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
    check_writes("b2b", base, e, 1);
    check("b2b pkt_count", pkt_count, 2);

    // fifo_full stall mid-payload
    do_reset();
    base = wq.size(); fb0 = fullc; fbad0 = fullbad;
    p = '{8'h10, 8'h20, 8'h30};
    fork
      send_pkt(p, 1);
      begin
        repeat (3) @(posedge wr_clk); #1;
        fifo_full = 1'b1;
        repeat (3) @(posedge wr_clk); #1;
        fifo_full = 1'b0;
      end
    join
    idle_in(); wait_idle();
    e = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h00};
    check_writes("stall", base, e, 0);
    check("stall cycles", fullc - fb0, 3);
    check("stall leak", fullbad - fbad0, 0);
    check("stall gap", cq[base+3] - cq[base+2], 4);

    // truncation at MAX_LEN, then exact-length packet
    do_reset();
    base = wq.size(); tb0 = tpulse;
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(p, 1); idle_in(); wait_idle();
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    check_writes("trunc", base, e, 1);
    check("trunc pulses", tpulse - tb0, 1);
    base = wq.size();
    p = '{8'h33}; send_pkt(p, 1); idle_in(); wait_idle();
    p = '{8'h0F, 8'hF0, 8'h01, 8'h02}; send_pkt(p, 1); idle_in(); wait_idle();
    e = '{8'h01, 8'h33, 8'h33, 8'h02, 8'h0F, 8'hF0, 8'h01, 8'h02, 8'hFC};
    check_writes("post trunc", base, e, 0);
    check("exact no trunc", tpulse - tb0, 1);
    check("post pkt_count", pkt_count, 3);

    // sequence wrap over 257 packets
    do_reset();
    base = wq.size();
    p = '{8'h5A};
    for (int k = 0; k < 257; k++) send_pkt(p, 1);
    idle_in(); wait_idle();
    check("wrap writes", wq.size() - base, 771);
    for (int k = 0; k < 257 && base + 3*k + 2 < wq.size(); k++) begin
      check($sformatf("wrap hdr%0d", k), wq[base+3*k], k % 256);
      check($sformatf("wrap trl%0d", k), wq[base+3*k+2], 8'h5A);
    end
    check("wrap pkt_count", pkt_count, 257);

    // async reset mid-packet
    p = '{8'h81, 8'h82};
    send_pkt(p, 0);
    idle_in();
    check("mid busy", busy, 1);
    #1 wr_rstn = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst wr_en", fifo_wr_en, 0);
    check("arst s_ready", s_ready, 0);
    check("arst pkt_count", pkt_count, 0);
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    @(posedge wr_clk); #1;
    base = wq.size();
    p = '{8'h0C, 8'h30};
    send_pkt(p, 1); idle_in(); wait_idle();
    e = '{8'h00, 8'h0C, 8'h30, 8'h3C};
    check_writes("after arst", base, e, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
